// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants, default divisor widths and oversample
//               modulus helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_DIV_W  = 16;
    localparam int DEFAULT_FRAC_W = 4;

    localparam logic OSR_16X = 1'b0;
    localparam logic OSR_8X  = 1'b1;

    // Oversample ticks per bit for the selected ratio.
    function automatic logic [4:0] os_modulus(input logic osr_sel);
        return (osr_sel == OSR_8X) ? 5'd8 : 5'd16;
    endfunction

    // Last os_cnt value before the wrap (N-1).
    function automatic logic [3:0] os_last(input logic osr_sel);
        return 4'(os_modulus(osr_sel) - 5'd1);
    endfunction

    // os_cnt value whose following tick lands on mid-bit (N/2-1).
    function automatic logic [3:0] os_mid_last(input logic osr_sel);
        return 4'((os_modulus(osr_sel) >> 1) - 5'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frac_div.sv
`default_nettype none
// ============================================================================
// Module      : frac_div
// Description : Integer-plus-fraction clock divider producing the oversample
//               tick. Period alternates between div_int and div_int+1 so the
//               mean is div_int + div_frac/2^FRAC_W clk cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W  = DEFAULT_DIV_W,
    parameter int FRAC_W = DEFAULT_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_fire,
    output logic              tick_os
);

    localparam logic [DIV_W-1:0] c_one = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic             r_tick_os;
    logic [FRAC_W:0]  w_sum;
    logic [DIV_W-1:0] w_carry;

    // A tick fires when the down-counter is exhausted and nothing forces a restart.
    assign os_fire = en & ~restart & (r_cnt == '0);
    assign w_sum   = {1'b0, r_acc} + {1'b0, div_frac};
    assign w_carry = {{(DIV_W-1){1'b0}}, w_sum[FRAC_W]};
    assign tick_os = r_tick_os;

    // Down-counter with fractional accumulator; carry stretches the next period by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '1;
            r_acc     <= '0;
            r_tick_os <= 1'b0;
        end else if (!en || restart) begin
            r_cnt     <= div_int - c_one;
            r_acc     <= '0;
            r_tick_os <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt     <= div_int - c_one + w_carry;
            r_acc     <= w_sum[FRAC_W-1:0];
            r_tick_os <= 1'b1;
        end else begin
            r_cnt     <= r_cnt - c_one;
            r_tick_os <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module      : baud_gen_frac
// Description : Fractional baud-rate generator. Shadowed config applied only
//               at a bit boundary or while idle, 8x/16x oversample counter,
//               bit and mid-bit ticks, resync and halt-on-zero-divisor.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int DIV_W  = DEFAULT_DIV_W,
    parameter int FRAC_W = DEFAULT_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  baud_div_int,
    input  logic [FRAC_W-1:0] baud_div_frac,
    input  logic              osr_sel,
    input  logic              resync,
    output logic              tick_os,
    output logic              tick_1x,
    output logic              tick_mid,
    output logic              cfg_pending,
    output logic              cfg_err
);

    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_sh_osr;
    logic              r_pending;
    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic              r_act_osr;
    logic              r_err;
    logic [3:0]        r_os_cnt;
    logic              r_tick_1x;
    logic              r_tick_mid;

    logic              w_halt;
    logic              w_restart;
    logic              w_os_fire;
    logic              w_wrap;
    logic              w_mid;
    logic              w_apply;
    logic [DIV_W-1:0]  w_next_int;
    logic [FRAC_W-1:0] w_next_frac;
    logic              w_next_osr;

    assign w_halt    = (r_act_int == '0);
    assign w_restart = resync | w_halt;

    // Wrap/mid decode uses the ratio in force for the bit now ending.
    assign w_wrap = w_os_fire & (r_os_cnt == os_last(r_act_osr));
    assign w_mid  = w_os_fire & (r_os_cnt == os_mid_last(r_act_osr));

    // Shadow becomes active while idle or on the tick that closes a bit, so the
    // divider reload on that same edge already uses the new period.
    assign w_apply     = r_pending & (~en | w_wrap);
    assign w_next_int  = w_apply ? r_sh_int  : r_act_int;
    assign w_next_frac = w_apply ? r_sh_frac : r_act_frac;
    assign w_next_osr  = w_apply ? r_sh_osr  : r_act_osr;

    frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .restart  (w_restart),
        .div_int  (w_next_int),
        .div_frac (w_next_frac),
        .os_fire  (w_os_fire),
        .tick_os  (tick_os)
    );

    // Shadow capture; a fresh load wins over a simultaneous apply of the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_int  <= '0;
            r_sh_frac <= '0;
            r_sh_osr  <= OSR_16X;
            r_pending <= 1'b0;
        end else if (cfg_load) begin
            r_sh_int  <= baud_div_int;
            r_sh_frac <= baud_div_frac;
            r_sh_osr  <= osr_sel;
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end
    end

    // Active config and error flag, updated together when the shadow is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_int  <= '0;
            r_act_frac <= '0;
            r_act_osr  <= OSR_16X;
            r_err      <= 1'b0;
        end else begin
            r_act_int  <= w_next_int;
            r_act_frac <= w_next_frac;
            r_act_osr  <= w_next_osr;
            r_err      <= (w_next_int == '0);
        end
    end

    // Oversample counter and registered bit/mid-bit ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_os_cnt   <= '0;
            r_tick_1x  <= 1'b0;
            r_tick_mid <= 1'b0;
        end else if (!en || w_restart) begin
            r_os_cnt   <= '0;
            r_tick_1x  <= 1'b0;
            r_tick_mid <= 1'b0;
        end else if (w_os_fire) begin
            r_os_cnt   <= w_wrap ? 4'd0 : r_os_cnt + 4'd1;
            r_tick_1x  <= w_wrap;
            r_tick_mid <= w_mid;
        end else begin
            r_tick_1x  <= 1'b0;
            r_tick_mid <= 1'b0;
        end
    end

    assign tick_1x     = r_tick_1x;
    assign tick_mid    = r_tick_mid;
    assign cfg_pending = r_pending;
    assign cfg_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module      : tb_baud_gen_frac
// Description : Self-checking bench for baud_gen_frac: config table, directed
//               corner sequences and a randomized run against a tick-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_baud_gen_frac;
    import uart_pkg::*;

    localparam int DIV_W    = DEFAULT_DIV_W;
    localparam int FRAC_W   = DEFAULT_FRAC_W;
    localparam int FRAC_ONE = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              en = 1'b0;
    logic              cfg_load = 1'b0;
    logic [DIV_W-1:0]  baud_div_int = '0;
    logic [FRAC_W-1:0] baud_div_frac = '0;
    logic              osr_sel = 1'b0;
    logic              resync = 1'b0;
    logic              tick_os, tick_1x, tick_mid, cfg_pending, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int div_i;
        int frac;
        bit osr;
        int first_os;
        int first_1x;
        int mid_after;
        int spacing;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    baud_gen_frac dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .cfg_load      (cfg_load),
        .baud_div_int  (baud_div_int),
        .baud_div_frac (baud_div_frac),
        .osr_sel       (osr_sel),
        .resync        (resync),
        .tick_os       (tick_os),
        .tick_1x       (tick_1x),
        .tick_mid      (tick_mid),
        .cfg_pending   (cfg_pending),
        .cfg_err       (cfg_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock edge; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the selected tick (0=os, 1=1x, 2=mid) is seen; -1000 on timeout.
    task automatic wait_for(input int which, input int limit, output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < limit) begin
            step();
            n++;
            case (which)
                0: hit = tick_os;
                1: hit = tick_1x;
                default: hit = tick_mid;
            endcase
        end
        if (!hit) n = -1000;
    endtask

    // Load a config with en low and let it settle into the active registers.
    task automatic cfg_idle(input int i, input int f, input bit o);
        en = 1'b0;
        baud_div_int = DIV_W'(i);
        baud_div_frac = FRAC_W'(f);
        osr_sel = o;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        step();
        step();
    endtask

    task automatic pulse_load(input int i, input int f, input bit o);
        baud_div_int = DIV_W'(i);
        baud_div_frac = FRAC_W'(f);
        osr_sel = o;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, a, b, c, cnt;
        int e, k, nmod, ci, cf;
        bit co, en_i, rs_i;
        int exp_v;

        vecs[0] = '{5, 0,  OSR_16X, 5, 80, 40, 80};
        vecs[1] = '{5, 8,  OSR_16X, 5, 87, 44, 88};
        vecs[2] = '{5, 0,  OSR_8X,  5, 40, 20, 40};
        vecs[3] = '{3, 4,  OSR_8X,  3, 25, 13, 26};
        vecs[4] = '{1, 0,  OSR_16X, 1, 16,  8, 16};
        vecs[5] = '{2, 15, OSR_8X,  2, 22, 12, 24};

        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        #1;
        check("reset_outputs", int'({tick_os, tick_1x, tick_mid, cfg_pending, cfg_err}), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        check("reset_cfg_err", int'(cfg_err), 1);
        check("reset_pending", int'(cfg_pending), 0);
        en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt += int'(tick_os) + int'(tick_1x) + int'(tick_mid);
        end
        check("halt_after_reset_ticks", cnt, 0);

        // ---------------- cfg_load while idle: second-cycle timing ----------------
        en = 1'b0;
        pulse_load(7, 0, OSR_16X);
        check("idle_load_pending_c1", int'(cfg_pending), 1);
        check("idle_load_err_c1", int'(cfg_err), 1);
        step();
        check("idle_load_pending_c2", int'(cfg_pending), 0);
        check("idle_load_err_c2", int'(cfg_err), 0);

        // ---------------- table of divisor/ratio configs ----------------
        for (int v = 0; v < 6; v++) begin
            cfg_idle(vecs[v].div_i, vecs[v].frac, vecs[v].osr);
            en = 1'b1;
            wait_for(0, 400, n);
            check($sformatf("v%0d_first_os", v), n, vecs[v].first_os);
            wait_for(1, 400, a);
            check($sformatf("v%0d_first_1x", v), n + a, vecs[v].first_1x);
            wait_for(2, 400, b);
            check($sformatf("v%0d_mid_after_1x", v), b, vecs[v].mid_after);
            wait_for(1, 400, c);
            check($sformatf("v%0d_1x_spacing", v), b + c, vecs[v].spacing);
        end

        // ---------------- runtime reload mid-bit ----------------
        cfg_idle(5, 0, OSR_16X);
        en = 1'b1;
        repeat (20) step();
        pulse_load(3, 0, OSR_16X);
        check("reload_pending", int'(cfg_pending), 1);
        wait_for(1, 200, n);
        check("reload_old_period_1x", n, 59);
        check("reload_pending_cleared", int'(cfg_pending), 0);
        wait_for(0, 50, n);
        check("reload_new_os_1", n, 3);
        wait_for(0, 50, n);
        check("reload_new_os_2", n, 3);

        // ---------------- resync on the would-be tick cycle ----------------
        cfg_idle(5, 0, OSR_16X);
        en = 1'b1;
        repeat (39) step();
        check("pre_resync_no_tick", int'(tick_os), 0);
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_suppressed", int'({tick_os, tick_1x, tick_mid}), 0);
        wait_for(0, 50, n);
        check("resync_next_os", n, 5);
        check("resync_first_not_1x", int'({tick_1x, tick_mid}), 0);
        wait_for(2, 200, a);
        check("resync_mid", n + a, 40);
        wait_for(1, 200, b);
        check("resync_1x", n + a + b, 80);

        // ---------------- load of zero divisor while running ----------------
        pulse_load(0, 0, OSR_16X);
        wait_for(1, 200, n);
        check("halt_load_1x", n, 79);
        check("halt_load_err", int'(cfg_err), 1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt += int'(tick_os) + int'(tick_1x) + int'(tick_mid);
        end
        check("halt_load_no_ticks", cnt, 0);
        check("halt_load_err_held", int'(cfg_err), 1);

        // ---------------- async reset mid-bit ----------------
        cfg_idle(5, 0, OSR_16X);
        check("pre_areset_err", int'(cfg_err), 0);
        en = 1'b1;
        wait_for(0, 50, n);
        check("pre_areset_os", n, 5);
        pulse_load(9, 0, OSR_8X);
        wait_for(0, 50, n);
        #2 rst_n = 1'b0;
        #1;
        check("areset_outputs", int'({tick_os, tick_1x, tick_mid, cfg_pending, cfg_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        repeat (3) step();
        check("areset_shadow_pending", int'(cfg_pending), 0);
        check("areset_shadow_err", int'(cfg_err), 1);

        // ---------------- randomized run against tick-time model ----------------
        for (int seg = 0; seg < 8; seg++) begin
            ci = int'($urandom_range(1, 6));
            cf = int'($urandom_range(0, FRAC_ONE - 1));
            co = 1'($urandom_range(0, 1));
            cfg_idle(ci, cf, co);
            check($sformatf("rand%0d_err", seg), int'(cfg_err), 0);
            nmod = co ? 8 : 16;
            e = 0;
            k = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                en_i = ($urandom_range(0, 149) != 0);
                rs_i = ($urandom_range(0, 199) == 0);
                en = en_i;
                resync = rs_i;
                step();
                exp_v = 0;
                if (!en_i || rs_i) begin
                    e = 0;
                    k = 0;
                end else begin
                    e++;
                    // Tick number k+1 lands at (k+1)*int + floor(k*frac/2^FRAC_W).
                    if (e == (k + 1) * ci + (k * cf) / FRAC_ONE) begin
                        k++;
                        exp_v = 4 + ((k % nmod == 0) ? 2 : 0) + ((k % nmod == nmod / 2) ? 1 : 0);
                    end
                end
                check($sformatf("rand%0d_c%0d_ticks", seg, cyc), int'({tick_os, tick_1x, tick_mid}), exp_v);
            end
            resync = 1'b0;
            check($sformatf("rand%0d_pending", seg), int'(cfg_pending), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
